// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Shares one req/ack memory bus between instruction fetch and data
//             access, buffers returned words and drops flushed fetches.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_stallreq,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INST_BUSY = 3'd1,
        INST_DROP = 3'd2,
        DATA_BUSY = 3'd3,
        DATA_DROP = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [3:0]    bus_sel_q, bus_sel_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic          bus_err_q, bus_err_d;
    logic          inst_valid_q, inst_valid_d;
    logic [31:0]   inst_buf_q, inst_buf_d;
    logic          data_valid_q, data_valid_d;
    logic [31:0]   data_buf_q, data_buf_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wd_fire;
    logic          unused_stall;

    assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

    // Fires on the last permitted wait cycle; an ack in that same cycle still wins.
    assign wd_fire = (MAX_WAIT != 0) && !bus_ack && ((32'(wd_cnt_q) + 32'd1) == MAX_WAIT);

    always_comb begin
        state_d      = state_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_err_d    = 1'b0;
        wd_cnt_d     = wd_cnt_q + CW'(1);
        inst_valid_d = inst_valid_q & stall[1] & ~flush;
        inst_buf_d   = inst_buf_q;
        data_valid_d = data_valid_q & stall[4] & ~flush;
        data_buf_d   = data_buf_q;

        case (state_q)
            IDLE: begin
                wd_cnt_d = '0;
                if (mem_ce && !data_valid_q && !flush) begin
                    state_d     = DATA_BUSY;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                end else if (if_ce && !inst_valid_q && !flush) begin
                    state_d    = INST_BUSY;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = 4'hF;
                    bus_addr_d = if_addr;
                end
            end
            INST_BUSY: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    if (!flush) begin
                        inst_valid_d = 1'b1;
                        inst_buf_d   = bus_rdata;
                    end
                end else if (wd_fire) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    if (!flush) begin
                        inst_valid_d = 1'b1;
                        inst_buf_d   = '0;
                    end
                end else if (flush) begin
                    state_d  = INST_DROP;
                    wd_cnt_d = '0;
                end
            end
            DATA_BUSY: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    if (!flush) begin
                        data_valid_d = 1'b1;
                        data_buf_d   = bus_rdata;
                    end
                end else if (wd_fire) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    if (!flush) begin
                        data_valid_d = 1'b1;
                        data_buf_d   = '0;
                    end
                end else if (flush) begin
                    state_d  = DATA_DROP;
                    wd_cnt_d = '0;
                end
            end
            INST_DROP, DATA_DROP: begin
                if (bus_ack) begin
                    state_d = IDLE;
                end else if (wd_fire) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        bus_req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_err_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_buf_q   <= '0;
            data_valid_q <= 1'b0;
            data_buf_q   <= '0;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_err_q    <= bus_err_d;
            inst_valid_q <= inst_valid_d;
            inst_buf_q   <= inst_buf_d;
            data_valid_q <= data_valid_d;
            data_buf_q   <= data_buf_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign if_rdata     = inst_buf_q;
    assign mem_rdata    = data_buf_q;
    assign if_stallreq  = if_ce & ~inst_valid_q;
    assign mem_stallreq = mem_ce & ~data_valid_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_sel      = bus_sel_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_err      = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Self-checking bench for bus_arbiter: scoreboard of per-cycle
//             expected outputs from a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_stallreq;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_err;

    bus_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_ce(if_ce), .if_addr(if_addr), .if_rdata(if_rdata), .if_stallreq(if_stallreq),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        err;
        logic        vi;
        logic        vd;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bi;
        logic [31:0] bd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: one outstanding transaction described by plain flags.
    bit          m_busy = 0, m_data = 0, m_drop = 0, m_err = 0, m_vi = 0, m_vd = 0, m_we = 0;
    int          m_wait = 0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_bi = '0, m_bd = '0;

    task automatic model_step();
        exp_t e;
        bit   nvi, nvd;
        if (rst) begin
            m_busy = 0; m_data = 0; m_drop = 0; m_err = 0; m_vi = 0; m_vd = 0; m_we = 0;
            m_wait = 0; m_sel = '0; m_addr = '0; m_wdata = '0; m_bi = '0; m_bd = '0;
        end else begin
            m_err = 0;
            nvi = m_vi && stall[1] && !flush;
            nvd = m_vd && stall[4] && !flush;
            if (!m_busy) begin
                if (mem_ce && !m_vd && !flush) begin
                    m_busy = 1; m_data = 1; m_drop = 0; m_wait = 0;
                    m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_wdata;
                end else if (if_ce && !m_vi && !flush) begin
                    m_busy = 1; m_data = 0; m_drop = 0; m_wait = 0;
                    m_we = 0; m_sel = 4'hF; m_addr = if_addr;
                end
            end else if (bus_ack) begin
                m_busy = 0;
                if (!m_drop && !flush) begin
                    if (m_data) begin nvd = 1; m_bd = bus_rdata; end
                    else        begin nvi = 1; m_bi = bus_rdata; end
                end
            end else begin
                m_wait++;
                if (MAXW != 0 && m_wait == MAXW) begin
                    m_busy = 0;
                    m_err  = 1;
                    if (!m_drop && !flush) begin
                        if (m_data) begin nvd = 1; m_bd = '0; end
                        else        begin nvi = 1; m_bi = '0; end
                    end
                end else if (flush && !m_drop) begin
                    m_drop = 1;
                    m_wait = 0;
                end
            end
            m_vi = nvi;
            m_vd = nvd;
        end
        e.req = m_busy; e.we = m_we; e.err = m_err; e.vi = m_vi; e.vd = m_vd;
        e.sel = m_sel; e.addr = m_addr; e.wdata = m_wdata; e.bi = m_bi; e.bd = m_bd;
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every cycle against the next scoreboard entry.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bus_req", bus_req, e.req);
            chk("bus_err", bus_err, e.err);
            chk("bus_we", bus_we, e.we);
            chk("bus_sel", bus_sel, e.sel);
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_wdata", bus_wdata, e.wdata);
            chk("if_rdata", if_rdata, e.bi);
            chk("mem_rdata", mem_rdata, e.bd);
            chk("if_stallreq", if_stallreq, if_ce & ~e.vi);
            chk("mem_stallreq", mem_stallreq, mem_ce & ~e.vd);
        end
    end

    // Bus slave: latency per transaction, 99 means never acknowledge.
    int          slave_lat_force = -1;
    bit          fix_en = 0, spurious_en = 0;
    logic [31:0] fix_data = '0;

    initial begin
        bit slave_active;
        int slave_w, slave_lat;
        slave_active = 0; slave_w = 0; slave_lat = 0;
        forever begin
            @(posedge clk);
            #1;
            bus_rdata = fix_en ? fix_data : $urandom;
            if (bus_req) begin
                if (!slave_active) begin
                    slave_active = 1;
                    slave_w = 0;
                    if (slave_lat_force >= 0) slave_lat = slave_lat_force;
                    else slave_lat = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
                end
                bus_ack = (slave_w == slave_lat);
                if (bus_ack) slave_active = 0;
                slave_w++;
            end else begin
                slave_active = 0;
                bus_ack = spurious_en && ($urandom_range(0, 7) == 0);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1; stall = '0; flush = 0; if_ce = 0; if_addr = '0;
        mem_ce = 0; mem_we = 0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
        step(2);
        rst = 0;

        // Zero-wait fetch
        slave_lat_force = 0; fix_en = 1; fix_data = 32'h3401_0001;
        if_ce = 1; if_addr = 32'h0;
        step(3); if_ce = 0; step(2);

        // Simultaneous requests: data goes first
        fix_en = 0;
        if_ce = 1; if_addr = 32'h40;
        mem_ce = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h100;
        step(3); mem_ce = 0; step(4); if_ce = 0; step(2);

        // Flush in the second cycle of a 3-wait fetch
        slave_lat_force = 3; fix_en = 1; fix_data = 32'h1111_1111;
        if_ce = 1; if_addr = 32'h20;
        step(2);
        flush = 1; if_addr = 32'h80;
        step(1);
        flush = 0;
        step(3); fix_data = 32'h2222_2222;
        step(6); if_ce = 0; step(2);

        // Held load result while MEM/WB stalls
        slave_lat_force = 0; fix_data = 32'hDEAD_BEEF;
        stall = 6'b010000; mem_ce = 1; mem_we = 0; mem_addr = 32'h200;
        step(5);
        stall = '0; mem_ce = 0;
        step(3);

        // Watchdog abort
        slave_lat_force = 99; if_ce = 1; if_addr = 32'h300;
        step(7); if_ce = 0; step(3);

        // Reset in the middle of a store
        mem_ce = 1; mem_we = 1; mem_sel = 4'h3; mem_addr = 32'h400; mem_wdata = 32'hCAFE_F00D;
        step(3);
        rst = 1; step(1);
        rst = 0; mem_ce = 0; step(3);

        // Randomized traffic
        slave_lat_force = -1; fix_en = 0; spurious_en = 1;
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            stall     = 6'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            if_ce     = ($urandom_range(0, 3) != 0);
            if_addr   = $urandom & 32'hFFFF_FFFC;
            mem_ce    = ($urandom_range(0, 2) == 0);
            mem_we    = 1'($urandom_range(0, 1));
            mem_sel   = 4'($urandom);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            step(1);
        end

        rst = 0; flush = 0; if_ce = 0; mem_ce = 0; stall = '0; spurious_en = 0;
        step(12);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
